// File: rtl/kronos_dmem_responder.sv
// kronos_dmem_responder: single-port data memory answering held rd/wr requests
// after a fixed number of wait states, with byte-masked writes and a sticky read register.
module kronos_dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  output logic [31:0] data_rd_data,
  output logic        data_gnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          req, enter_grant, unused_addr;
  assign req          = data_rd_req | data_wr_req;
  assign idx          = data_addr[AW+1:2];
  assign unused_addr  = ^{data_addr[31:AW+2], data_addr[1:0]};
  assign data_gnt     = gnt_q;
  assign data_rd_data = rd_data_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req) begin
        cnt_d   = WC;
        state_d = (WC == 4'd0) ? GRANT : WAIT;
      end
      WAIT: begin
        cnt_d   = (req && cnt_q != 4'd1) ? cnt_q - 4'd1 : 4'd0;
        state_d = !req ? IDLE : (cnt_q == 4'd1) ? GRANT : WAIT;
      end
      default: state_d = IDLE;
    endcase
    // GRANT always returns to IDLE, so reaching GRANT here means a fresh access
    enter_grant = rstz && state_d == GRANT;
    gnt_d       = enter_grant;
    rd_data_d   = (enter_grant && data_rd_req && !data_wr_req) ? mem_q[idx] : rd_data_q;
  end
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enter_grant && data_wr_req)
      for (int i = 0; i < 4; i++)
        if (data_wr_mask[i]) mem_q[idx][8*i +: 8] <= data_wr_data[8*i +: 8];
  end
endmodule

// File: tb/tb_kronos_dmem_responder.sv
// tb_kronos_dmem_responder: scoreboard bench driving a zero-wait and a three-wait responder
// against a word-array model with a cycle-level grant timing model.
module tb_kronos_dmem_responder;
  typedef struct {
    int          cyc;
    logic [31:0] rd;
  } exp_t;
  logic        clk = 1'b0;
  logic        rstz;
  logic        rd_req [2];
  logic        wr_req [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  mask   [2];
  logic [31:0] rdata  [2];
  logic        gnt    [2];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  int          g_last [2];
  logic [31:0] last_rd [2];
  logic [31:0] mem_m [2][256];
  exp_t        q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  kronos_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstz(rstz), .data_addr(addr[0]), .data_rd_req(rd_req[0]),
    .data_wr_req(wr_req[0]), .data_wr_data(wdata[0]), .data_wr_mask(mask[0]),
    .data_rd_data(rdata[0]), .data_gnt(gnt[0]));
  kronos_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rstz(rstz), .data_addr(addr[1]), .data_rd_req(rd_req[1]),
    .data_wr_req(wr_req[1]), .data_wr_data(wdata[1]), .data_wr_mask(mask[1]),
    .data_rd_data(rdata[1]), .data_gnt(gnt[1]));
  function automatic int wc(input int k);
    return k == 0 ? 0 : 3;
  endfunction
  function automatic int dep(input int k);
    return k == 0 ? 256 : 16;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drop(input int k);
    rd_req[k] = 1'b0;
    wr_req[k] = 1'b0;
    addr[k]   = $urandom;
    wdata[k]  = $urandom;
    mask[k]   = 4'($urandom);
  endtask
  // Issue one access, record its expected grant cycle and read value, hold until granted.
  task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    int   w, acc, n;
    exp_t e;
    w = int'((a >> 2) % 32'(dep(k)));
    if (wr) begin
      for (int i = 0; i < 4; i++) if (m[i]) mem_m[k][w][8*i +: 8] = d[8*i +: 8];
    end else last_rd[k] = mem_m[k][w];
    acc       = (cyc > g_last[k]) ? cyc : g_last[k] + 1;
    e.cyc     = acc + wc(k) + 1;
    e.rd      = last_rd[k];
    g_last[k] = e.cyc;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    rd_req[k] = rd;
    wr_req[k] = wr;
    addr[k]   = a;
    wdata[k]  = d;
    mask[k]   = m;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!gnt[k] && n < 40);
    chk($sformatf("gnt_handshake%0d", k), 32'(gnt[k]), 32'd1);
    drop(k);
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (gnt[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("unexpected_gnt%0d", k), 32'(gnt[k]), 32'd0);
        else begin
          exp_t e;
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("gnt_cycle%0d", k), 32'(cyc), 32'(e.cyc));
          chk($sformatf("rd_data%0d", k), rdata[k], e.rd);
        end
      end
    end
  end
  initial begin
    rstz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drop(k);
      g_last[k]  = -10;
      last_rd[k] = 32'h0;
    end
    idle(3);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_gnt%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("reset_rd_data%0d", k), rdata[k], 32'h0);
    end
    rstz = 1'b1;
    idle(2);
    for (int i = 0; i < 256; i++) access(0, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 16; i++) access(1, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
    idle(2);
    access(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    chk("read_deadbeef", rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF);
    access(0, 1'b0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("byte_mask", rdata[0], 32'h11BB33DD);
    access(0, 1'b0, 1'b1, 32'h400, 32'h5A5A5A5A, 4'hF);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("alias_0x000", rdata[0], 32'h5A5A5A5A);
    access(0, 1'b1, 1'b0, 32'h3, 32'h0, 4'h0);
    chk("alias_0x003", rdata[0], 32'h5A5A5A5A);
    access(0, 1'b1, 1'b1, 32'h8, 32'h12345678, 4'hF);
    chk("rdwr_keeps_rd_data", rdata[0], 32'h5A5A5A5A);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    chk("read_after_rdwr", rdata[0], 32'h12345678);
    idle(3);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    idle(3);
    rd_req[1] = 1'b0;
    wr_req[1] = 1'b1;
    addr[1]   = 32'h24;
    wdata[1]  = 32'hCAFEF00D;
    mask[1]   = 4'hF;
    idle(2);
    drop(1);
    idle(6);
    access(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    chk("abort_keeps_mem", rdata[1], mem_m[1][9]);
    wr_req[1] = 1'b1;
    addr[1]   = 32'h28;
    wdata[1]  = 32'hBADC0DE5;
    mask[1]   = 4'hF;
    idle(1);
    rstz = 1'b0;
    drop(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wait_reset_gnt%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("wait_reset_rd_data%0d", k), rdata[k], 32'h0);
      last_rd[k] = 32'h0;
      g_last[k]  = -10;
    end
    idle(1);
    rstz = 1'b1;
    idle(8);
    access(1, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
    for (int n = 0; n < 80; n++) begin
      int k, kind;
      k    = int'($urandom_range(1, 0));
      kind = int'($urandom_range(2, 0));
      access(k, kind != 1, kind != 0, $urandom, $urandom, 4'($urandom));
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
    end
    idle(10);
    chk("drained0", 32'(q0.size()), 32'd0);
    chk("drained1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/kronos_dmem_responder.md
KRONOS_DMEM_RESPONDER -- requirements
Module: kronos_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, data memory size in 32b words (power of 2, >=2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra wait states inserted before each grant (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstz  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port data_addr  input  32  byte address from initiator.
REQ-006 SHALL have port data_rd_req  input  1  read request; held until grant.
REQ-007 SHALL have port data_wr_req  input  1  write request; held until grant.
REQ-008 SHALL have port data_wr_data  input  32  write data.
REQ-009 SHALL have port data_wr_mask  input  4  byte enables; bit i enables byte [8i+7:8i].
REQ-010 SHALL have port data_rd_data  output  32  read data, registered.
REQ-011 SHALL have port data_gnt  output  1  one-cycle completion pulse, registered.

Function
REQ-012 SHALL implement FSM with states IDLE, WAIT, GRANT; reset state IDLE.
REQ-013 IDLE: data_rd_req|data_wr_req high at a clock edge -> load wait counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else GRANT.
REQ-014 WAIT: counter decrements each cycle; counter==1 at edge with request still high -> GRANT.
REQ-015 Request sampled in cycle 0 SHALL yield data_gnt high in cycle WAIT_CYCLES+1 and low in all other cycles.
REQ-016 GRANT SHALL last exactly one cycle, then IDLE unconditionally; IDLE SHALL NOT accept on the edge leaving GRANT, so back-to-back accesses complete every WAIT_CYCLES+2 cycles.
REQ-017 Both requests dropped during WAIT -> abort to IDLE at that edge; no memory write; no grant; data_rd_data unchanged.
REQ-018 Word index SHALL be data_addr[log2(DEPTH)+1:2]; bits [1:0] and upper bits ignored (addresses alias modulo 4*DEPTH).
REQ-019 Address, data, mask SHALL be sampled on the edge entering GRANT; values in earlier request cycles are don't-care.
REQ-020 Write: on edge entering GRANT, only bytes with mask bit set SHALL be updated; mask 4'b0000 -> grant issued, memory unchanged.
REQ-021 Read: on edge entering GRANT, data_rd_data SHALL load the addressed word; it SHALL hold that value until the next read grant (unchanged across writes, aborts, idle).
REQ-022 data_rd_req and data_wr_req both high: write SHALL take priority; one grant; data_rd_data unchanged.
REQ-023 Read of a word written in an earlier grant SHALL return the post-write value (no stale data).
REQ-024 Memory array SHALL NOT be reset; contents undefined until written.

Reset
REQ-025 rstz low SHALL immediately force data_gnt=0, data_rd_data=32'h0, state IDLE, counter 0.
REQ-026 Reset in WAIT SHALL drop pending access: no write, no grant after release.
REQ-027 First request accepted no earlier than the first rising edge with rstz high.

Verification
REQ-028 WAIT_CYCLES=0: write 0x100 data 0xDEADBEEF mask 4'hF, then read 0x100 -> each gnt one cycle after req; read returns 0xDEADBEEF.
REQ-029 Byte mask: write 0x0 data 0x11223344 mask F, write 0x0 data 0xAABBCCDD mask 4'b0101 -> read 0x0 returns 0x11BB33DD.
REQ-030 WAIT_CYCLES=3: hold read req from cycle 0 -> gnt high only in cycle 4; next accepted request grants no earlier than cycle 9.
REQ-031 WAIT_CYCLES=3: write req dropped in cycle 2 -> no gnt; subsequent read of that address returns prior contents.
REQ-032 DEPTH=256: write 0x400 data 0x5A5A5A5A -> read 0x000 returns 0x5A5A5A5A; read 0x003 same word.
REQ-033 Simultaneous rd+wr to 0x8 data 0x12345678 -> single gnt, data_rd_data unchanged; later read 0x8 returns 0x12345678; rstz pulse in WAIT -> gnt stays 0, data_rd_data=0.
